// File: rtl/fpmac_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fpmac_pkg : shared constants, reporter state type, nibble-to-ASCII    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package fpmac_pkg;

    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam int         FRAME_BYTES = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } reporter_state_t;

    // Uppercase hex: 0-9 -> '0'..'9', A-F -> 'A'..'F' (0x41 - 10 = 0x37)
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) return 8'h30 + {4'h0, nib};
        else             return 8'h37 + {4'h0, nib};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp16_uart_reporter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp16_uart_reporter_if : result strobe in, UART line status out        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface fp16_uart_reporter_if;

    logic        result_valid;
    logic [15:0] result;
    logic [3:0]  acc_count;
    logic        busy;
    logic        tx;
    logic        dropped;
    logic        frame_done;

    modport master (
        output result_valid, result, acc_count,
        input  busy, tx, dropped, frame_done
    );

    modport slave (
        input  result_valid, result, acc_count,
        output busy, tx, dropped, frame_done
    );

endinterface
`default_nettype wire

// File: rtl/fp16_uart_reporter_uart_tx_byte.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_byte : one 8N1 character, LSB first, idle-high tx             |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data8,
    output logic       tx,
    output logic       bit_tick,
    output logic [3:0] bit_idx,
    output logic       done
);

    localparam logic [CNT_W-1:0] c_BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic             r_active;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [3:0]       r_bit_idx;
    logic [9:0]       r_shift;
    logic             r_tx;

    assign bit_tick = r_active && (r_baud_cnt == c_BAUD_LAST);
    assign done     = bit_tick && (r_bit_idx == 4'd9);
    assign bit_idx  = r_bit_idx;
    assign tx       = r_tx;

    // Bit 0 is the start bit, bits 1-8 data, bit 9 the stop bit
    always_ff @(posedge clock) begin
        if (reset) begin
            r_active   <= 1'b0;
            r_baud_cnt <= '0;
            r_bit_idx  <= 4'd0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
        end else if (!r_active) begin
            if (start) begin
                r_active   <= 1'b1;
                r_baud_cnt <= '0;
                r_bit_idx  <= 4'd0;
                r_shift    <= {1'b1, data8, 1'b0};
                r_tx       <= 1'b0;
            end
        end else if (bit_tick) begin
            r_baud_cnt <= '0;
            if (r_bit_idx == 4'd9) begin
                r_active  <= 1'b0;
                r_bit_idx <= 4'd0;
                r_tx      <= 1'b1;
            end else begin
                r_bit_idx <= r_bit_idx + 4'd1;
                r_shift   <= {1'b1, r_shift[9:1]};
                r_tx      <= r_shift[1];
            end
        end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp16_uart_reporter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp16_uart_reporter : logs each FP16 MAC result as "C:HHHH\r\n" on UART |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module fp16_uart_reporter
    import fpmac_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    fp16_uart_reporter_if.slave  rpt
);

    localparam logic [2:0] c_LAST_BYTE = 3'(FRAME_BYTES - 1);

    reporter_state_t r_state;
    logic [15:0]     r_result;
    logic [3:0]      r_acc_count;
    logic [2:0]      r_byte_idx;
    logic            r_busy;
    logic            r_dropped;
    logic            r_frame_done;

    logic [7:0]      w_byte;
    logic            w_start;
    logic            w_tx;
    logic            w_bit_tick;
    logic [3:0]      w_bit_idx;
    logic            w_done;

    always_comb begin
        w_byte = ASCII_LF;
        case (r_byte_idx)
            3'd0:    w_byte = nibble_to_ascii(r_acc_count);
            3'd1:    w_byte = ASCII_COLON;
            3'd2:    w_byte = nibble_to_ascii(r_result[15:12]);
            3'd3:    w_byte = nibble_to_ascii(r_result[11:8]);
            3'd4:    w_byte = nibble_to_ascii(r_result[7:4]);
            3'd5:    w_byte = nibble_to_ascii(r_result[3:0]);
            3'd6:    w_byte = ASCII_CR;
            default: w_byte = ASCII_LF;
        endcase
    end

    assign w_start = (r_state == LOAD);

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_tx (
        .clock    (clock),
        .reset    (reset),
        .start    (w_start),
        .data8    (w_byte),
        .tx       (w_tx),
        .bit_tick (w_bit_tick),
        .bit_idx  (w_bit_idx),
        .done     (w_done)
    );

    // busy stays high through the frame_done cycle so a strobe there is dropped
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_result     <= '0;
            r_acc_count  <= '0;
            r_byte_idx   <= '0;
            r_busy       <= 1'b0;
            r_dropped    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (rpt.result_valid && r_busy) r_dropped <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (r_busy) begin
                        r_busy <= 1'b0;
                    end else if (rpt.result_valid) begin
                        r_result    <= rpt.result;
                        r_acc_count <= rpt.acc_count;
                        r_busy      <= 1'b1;
                        r_state     <= LOAD;
                    end
                end
                LOAD:  r_state <= START;
                START: if (w_bit_tick) r_state <= DATA;
                DATA:  if (w_bit_tick && (w_bit_idx == 4'd8)) r_state <= STOP;
                STOP: begin
                    if (w_done) begin
                        if (r_byte_idx == c_LAST_BYTE) begin
                            r_byte_idx   <= '0;
                            r_frame_done <= 1'b1;
                            r_state      <= IDLE;
                        end else begin
                            r_byte_idx <= r_byte_idx + 3'd1;
                            r_state    <= LOAD;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rpt.busy       = r_busy;
    assign rpt.tx         = w_tx;
    assign rpt.dropped    = r_dropped;
    assign rpt.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_fp16_uart_reporter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fp16_uart_reporter : directed line-decode bench, CLKS_PER_BIT = 4  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_fp16_uart_reporter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   fd_count = 0;
    time  fd_time = 0;

    fp16_uart_reporter_if rpt_if ();

    fp16_uart_reporter #(
        .CLKS_PER_BIT (4),
        .CNT_W        (16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .rpt   (rpt_if)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (rpt_if.frame_done === 1'b1) begin
            fd_count++;
            fd_time = $time;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        rpt_if.result_valid = 1'b0;
        rpt_if.result = 16'h0000;
        rpt_if.acc_count = 4'h0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
    endtask

    // Waits for a start bit (bounded), then samples mid-bit at 4 clocks/bit
    task automatic rx_byte(output logic [7:0] b, output time ts, output bit ok);
        int n;
        ok = 1'b0;
        b  = 8'h00;
        ts = 0;
        n  = 0;
        while (rpt_if.tx !== 1'b0 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (rpt_if.tx !== 1'b0) return;
        ts = $time;
        repeat (2) @(negedge clock);
        if (rpt_if.tx !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (4) @(negedge clock);
            b[i] = rpt_if.tx;
        end
        repeat (4) @(negedge clock);
        ok = (rpt_if.tx === 1'b1);
    endtask

    task automatic rx_line(output logic [63:0] line, output time t_first, output bit ok);
        logic [7:0] b;
        time        ts;
        bit         okb;
        line    = '0;
        t_first = 0;
        ok      = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rx_byte(b, ts, okb);
            if (!okb) begin
                ok = 1'b0;
                return;
            end
            if (k == 0) t_first = ts;
            line = {line[55:0], b};
        end
    endtask

    task automatic strobe(input logic [15:0] r, input logic [3:0] c, output time t0);
        @(negedge clock);
        rpt_if.result_valid = 1'b1;
        rpt_if.result = r;
        rpt_if.acc_count = c;
        t0 = $time;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (rpt_if.tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b want 1", rpt_if.tx); end
        n_vec++; if (rpt_if.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", rpt_if.busy); end
        n_vec++; if (rpt_if.dropped !== 1'b0) begin n_err++; $display("FAIL reset_dropped: got %b want 0", rpt_if.dropped); end
        n_vec++; if (rpt_if.frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done: got %b want 0", rpt_if.frame_done); end
    endtask

    task automatic test_idle();
        int bad;
        int fd0;
        do_reset();
        bad = 0;
        fd0 = fd_count;
        repeat (1000) begin
            @(negedge clock);
            if (rpt_if.tx !== 1'b1 || rpt_if.busy !== 1'b0 || rpt_if.frame_done !== 1'b0) bad++;
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL idle_quiet: got %0d bad cycles want 0", bad); end
        n_vec++; if (fd_count != fd0) begin n_err++; $display("FAIL idle_frame_done: got %0d pulses want 0", fd_count - fd0); end
    endtask

    task automatic test_basic();
        logic [63:0] line;
        time t0, ts;
        bit ok;
        int fd0;
        fd0 = fd_count;
        strobe(16'h3C00, 4'h5, t0);
        @(negedge clock);
        rpt_if.result_valid = 1'b0;
        rx_line(line, ts, ok);
        repeat (5) @(negedge clock);
        n_vec++; if (!ok || line !== {"5:3C00", 8'h0D, 8'h0A}) begin n_err++; $display("FAIL basic_line: got %h ok=%0d want %h", line, ok, {"5:3C00", 8'h0D, 8'h0A}); end
        n_vec++; if (fd_count - fd0 != 1) begin n_err++; $display("FAIL basic_frame_done_count: got %0d want 1", fd_count - fd0); end
        n_vec++; if (fd_time - t0 != 3290) begin n_err++; $display("FAIL basic_frame_done_time: got %0t want 3290 after strobe", fd_time - t0); end
        n_vec++; if (rpt_if.busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_after: got %b want 0", rpt_if.busy); end
        n_vec++; if (rpt_if.dropped !== 1'b0) begin n_err++; $display("FAIL basic_dropped: got %b want 0", rpt_if.dropped); end
    endtask

    task automatic test_uppercase();
        logic [63:0] line;
        time t0, ts;
        bit ok;
        strobe(16'hABCD, 4'hF, t0);
        @(negedge clock);
        rpt_if.result_valid = 1'b0;
        rx_line(line, ts, ok);
        repeat (5) @(negedge clock);
        n_vec++; if (!ok || line !== {"F:ABCD", 8'h0D, 8'h0A}) begin n_err++; $display("FAIL upper_line: got %h ok=%0d want %h", line, ok, {"F:ABCD", 8'h0D, 8'h0A}); end
        n_vec++; if (ts - t0 != 20) begin n_err++; $display("FAIL upper_start_latency: got %0t want 20", ts - t0); end
    endtask

    task automatic test_drop_busy();
        logic [63:0] line;
        time t0, ts;
        bit ok;
        int fd0;
        int starts;
        fd0 = fd_count;
        strobe(16'h0F0F, 4'h2, t0);
        fork
            rx_line(line, ts, ok);
            begin
                @(negedge clock);
                rpt_if.result_valid = 1'b0;
                repeat (134) @(negedge clock);
                rpt_if.result_valid = 1'b1;
                rpt_if.result = 16'h1234;
                rpt_if.acc_count = 4'h7;
                @(negedge clock);
                rpt_if.result_valid = 1'b0;
            end
        join
        starts = 0;
        repeat (200) begin
            @(negedge clock);
            if (rpt_if.tx !== 1'b1) starts++;
        end
        n_vec++; if (!ok || line !== {"2:0F0F", 8'h0D, 8'h0A}) begin n_err++; $display("FAIL drop_line: got %h ok=%0d want %h", line, ok, {"2:0F0F", 8'h0D, 8'h0A}); end
        n_vec++; if (rpt_if.dropped !== 1'b1) begin n_err++; $display("FAIL drop_flag: got %b want 1", rpt_if.dropped); end
        n_vec++; if (starts != 0) begin n_err++; $display("FAIL drop_no_second_line: got %0d low cycles want 0", starts); end
        n_vec++; if (fd_count - fd0 != 1) begin n_err++; $display("FAIL drop_frame_done_count: got %0d want 1", fd_count - fd0); end
    endtask

    task automatic test_frame_done_collision();
        logic [63:0] line;
        time t0, t1, ts;
        bit ok;
        do_reset();
        strobe(16'h7E00, 4'h3, t0);
        fork
            rx_line(line, ts, ok);
            begin
                @(negedge clock);
                rpt_if.result_valid = 1'b0;
                repeat (328) @(negedge clock);
                n_vec++; if (rpt_if.frame_done !== 1'b1 || rpt_if.busy !== 1'b1) begin n_err++; $display("FAIL coll_fd_cycle: got frame_done=%b busy=%b want 1 1", rpt_if.frame_done, rpt_if.busy); end
                rpt_if.result_valid = 1'b1;
                rpt_if.result = 16'hDEAD;
                rpt_if.acc_count = 4'h9;
                @(negedge clock);
                rpt_if.result = 16'h0001;
                rpt_if.acc_count = 4'h1;
                t1 = $time;
                @(negedge clock);
                rpt_if.result_valid = 1'b0;
            end
        join
        n_vec++; if (!ok || line !== {"3:7E00", 8'h0D, 8'h0A}) begin n_err++; $display("FAIL coll_first_line: got %h ok=%0d want %h", line, ok, {"3:7E00", 8'h0D, 8'h0A}); end
        n_vec++; if (rpt_if.dropped !== 1'b1) begin n_err++; $display("FAIL coll_dropped: got %b want 1", rpt_if.dropped); end
        rx_line(line, ts, ok);
        repeat (5) @(negedge clock);
        n_vec++; if (!ok || line !== {"1:0001", 8'h0D, 8'h0A}) begin n_err++; $display("FAIL coll_second_line: got %h ok=%0d want %h", line, ok, {"1:0001", 8'h0D, 8'h0A}); end
        n_vec++; if (ts - t1 != 20) begin n_err++; $display("FAIL coll_second_latency: got %0t want 20", ts - t1); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] line;
        time t0, ts;
        bit ok;
        int fd0;
        fd0 = fd_count;
        strobe(16'hC5A0, 4'h6, t0);
        @(negedge clock);
        rpt_if.result_valid = 1'b0;
        repeat (100) @(negedge clock);
        n_vec++; if (rpt_if.tx !== 1'b0 || rpt_if.busy !== 1'b1) begin n_err++; $display("FAIL mid_pre_reset: got tx=%b busy=%b want 0 1", rpt_if.tx, rpt_if.busy); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_vec++; if (rpt_if.tx !== 1'b1) begin n_err++; $display("FAIL mid_tx: got %b want 1", rpt_if.tx); end
        n_vec++; if (rpt_if.busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b want 0", rpt_if.busy); end
        n_vec++; if (rpt_if.dropped !== 1'b0) begin n_err++; $display("FAIL mid_dropped: got %b want 0", rpt_if.dropped); end
        repeat (10) @(negedge clock);
        strobe(16'h8001, 4'hA, t0);
        @(negedge clock);
        rpt_if.result_valid = 1'b0;
        rx_line(line, ts, ok);
        repeat (5) @(negedge clock);
        n_vec++; if (!ok || line !== {"A:8001", 8'h0D, 8'h0A}) begin n_err++; $display("FAIL mid_new_line: got %h ok=%0d want %h", line, ok, {"A:8001", 8'h0D, 8'h0A}); end
        n_vec++; if (fd_count - fd0 != 1) begin n_err++; $display("FAIL mid_frame_done_count: got %0d want 1", fd_count - fd0); end
    endtask

    initial begin
        rpt_if.result_valid = 1'b0;
        rpt_if.result = 16'h0000;
        rpt_if.acc_count = 4'h0;
        test_reset();
        test_idle();
        test_basic();
        test_uppercase();
        test_drop_busy();
        test_frame_done_collision();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
